cacheline_adaptor: RTL and testbench

Sits directly downstream of the two-way cache, between the cache's physical-memory port and main memory. Converts a single 256-bit cacheline read or write request from cache control into a 4-beat 64-bit burst transaction on the memory bus. Assembles incoming read beats into a full line and slices a latched line into outgoing write beats. Raises a one-cycle line response back to the cache when the burst completes.

---
 rtl/cache_types_pkg.sv | 29 ++
 rtl/line_buffer.sv | 41 ++++
 rtl/cacheline_adaptor.sv | 125 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Shared types and constants for the cacheline adaptor.
//   LINE_W   : cacheline width in bits
//   BURST_W  : memory beat width in bits (LINE_W is an exact multiple)
//   ADDR_W   : address width
//   BEATS    : beats per line (derived, not overridable)
//   CNT_W    : beat counter width
//   OFFSET_W : byte-offset bits within a line, forced to 0 on the memory side
package cache_types_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } adaptor_state_e;

endpackage

// File: rtl/line_buffer.sv
// Cacheline storage register for the adaptor.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset, clears the line
//   load     : load the full line from line_in (takes priority over beat_we)
//   line_in  : full line to load
//   beat_we  : write beat_in into the beat slot selected by idx
//   idx      : beat index for both the beat write and beat_out
//   beat_in  : incoming beat
//   line     : current line contents
//   beat_out : beat slot selected by idx
module line_buffer
  import cache_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  line_t line_in,
  input  logic  beat_we,
  input  cnt_t  idx,
  input  beat_t beat_in,
  output line_t line,
  output beat_t beat_out
);

  line_t line_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= line_in;
    end else if (beat_we) begin
      line_q[idx*BURST_W +: BURST_W] <= beat_in;
    end
  end

  assign line     = line_q;
  assign beat_out = line_q[idx*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write from the cache into a BEATS-long burst on
// the memory bus, and returns a one-cycle resp_o when the burst completes.
// Ports:
//   clk, rst   : clock and synchronous active-low reset
//   address_i  : line address from the cache
//   read_i     : line read request
//   write_i    : line write request
//   line_i     : line to write back
//   line_o     : assembled line (valid while resp_o=1)
//   resp_o     : one-cycle completion to the cache
//   address_o  : line-aligned burst base address
//   read_o     : burst read request
//   write_o    : burst write request
//   burst_o    : current write beat (0 outside WRITE)
//   burst_i    : read beat from memory
//   resp_i     : beat valid (read) / beat accepted (write)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request; read_i wins over write_i
// S_READ  | read_o=1, capture burst_i into beat cnt on each resp_i
// S_WRITE | write_o=1, present beat cnt on burst_o, advance on resp_i
// S_DONE  | resp_o=1 for one cycle, then back to idle unconditionally
module cacheline_adaptor
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam cnt_t  CNT_LAST   = cnt_t'(BEATS - 1);
  localparam addr_t ALIGN_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  adaptor_state_e state_q, state_d;
  cnt_t           cnt_q;
  addr_t          addr_q;
  logic           load;
  logic           beat_we;
  logic           start;
  beat_t          beat_out;
  line_t          line_buf;

  assign start = (state_q == S_IDLE) && (read_i || write_i);

  always_comb begin
    state_d = state_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    load    = 1'b0;
    beat_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_i) begin
          state_d = S_READ;
        end else if (write_i) begin
          state_d = S_WRITE;
          load    = 1'b1;
        end
      end
      S_READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          beat_we = 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        write_o = 1'b1;
        if (resp_i && (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        resp_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q  <= '0;
        addr_q <= address_i & ALIGN_MASK;
      end else if ((state_q == S_READ || state_q == S_WRITE) && resp_i) begin
        // wraps back to 0 after the last beat
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  line_buffer u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .line_in  (line_i),
    .beat_we  (beat_we),
    .idx      (cnt_q),
    .beat_in  (burst_i),
    .line     (line_buf),
    .beat_out (beat_out)
  );

  assign line_o    = line_buf;
  assign address_o = addr_q;
  assign burst_o   = (state_q == S_WRITE) ? beat_out : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] D0 = 64'hD0D0_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'hD1D1_1111_0000_00D1;
  localparam logic [63:0] D2 = 64'hD2D2_2222_0000_00D2;
  localparam logic [63:0] D3 = 64'hD3D3_3333_0000_00D3;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] rbeats [4];
    logic [63:0] stall_beat [7];
    logic        stall_resp [7];
    logic        wr_resp [6];
    logic [63:0] wr_exp [6];
    logic [255:0] last_line;

    // reset
    rst = 1'b0;
    tick();
    tick();
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_address_o", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_line_o", line_o, 0);
    rst = 1'b1;
    tick();

    // read, no stalls
    rbeats = '{B1, B2, B3, B4};
    address_i = 32'h0000_1234;
    read_i = 1'b1;
    tick();
    chk("rd_address_o", address_o, 32'h0000_1220);
    for (int i = 0; i < 4; i++) begin
      chk("rd_read_o_held", read_o, 1);
      chk("rd_resp_o_low", resp_o, 0);
      resp_i = 1'b1;
      burst_i = rbeats[i];
      tick();
    end
    resp_i = 1'b0;
    burst_i = JUNK;
    chk("rd_done_read_o", read_o, 0);
    chk("rd_done_resp_o", resp_o, 1);
    chk("rd_done_line_o", line_o, {B4, B3, B2, B1});
    tick();
    read_i = 1'b0;
    chk("rd_after_resp_o", resp_o, 0);
    chk("rd_after_read_o", read_o, 0);
    tick();

    // read with stalls: a junk beat on each stall must not be captured
    stall_resp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    stall_beat = '{B1, JUNK, B2, JUNK, B3, JUNK, B4};
    read_i = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("rds_read_o_held", read_o, 1);
      chk("rds_resp_o_low", resp_o, 0);
      resp_i = stall_resp[i];
      burst_i = stall_beat[i];
      tick();
    end
    resp_i = 1'b0;
    chk("rds_done_resp_o", resp_o, 1);
    chk("rds_done_line_o", line_o, {B4, B3, B2, B1});
    tick();
    read_i = 1'b0;
    chk("rds_resp_once", resp_o, 0);
    tick();

    // write with stalled beats; inputs changed mid-burst must be ignored
    wr_resp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    wr_exp  = '{D0, D0, D1, D2, D2, D3};
    address_i = 32'h8000_0040;
    line_i = {D3, D2, D1, D0};
    write_i = 1'b1;
    tick();
    chk("wr_address_o", address_o, 32'h8000_0040);
    address_i = 32'h0000_0000;
    line_i = '0;
    for (int i = 0; i < 6; i++) begin
      chk("wr_write_o_held", write_o, 1);
      chk("wr_burst_o", burst_o, wr_exp[i]);
      chk("wr_resp_o_low", resp_o, 0);
      resp_i = wr_resp[i];
      tick();
    end
    resp_i = 1'b0;
    chk("wr_done_write_o", write_o, 0);
    chk("wr_done_resp_o", resp_o, 1);
    chk("wr_done_burst_o", burst_o, 0);
    chk("wr_done_line_o", line_o, {D3, D2, D1, D0});
    tick();
    write_i = 1'b0;
    chk("wr_resp_once", resp_o, 0);
    tick();

    // priority: read and write together, requests held through DONE
    address_i = 32'h0000_00FF;
    line_i = {4{JUNK}};
    read_i = 1'b1;
    write_i = 1'b1;
    tick();
    chk("pri_read_o", read_o, 1);
    chk("pri_write_o", write_o, 0);
    chk("pri_address_o", address_o, 32'h0000_00E0);
    rbeats = '{B4, B3, B2, B1};
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = rbeats[i];
      tick();
    end
    resp_i = 1'b0;
    chk("pri_done_resp_o", resp_o, 1);
    chk("pri_done_line_o", line_o, {B1, B2, B3, B4});
    tick();
    chk("b2b_no_retrig_read_o", read_o, 0);
    chk("b2b_no_retrig_write_o", write_o, 0);
    chk("b2b_no_retrig_resp_o", resp_o, 0);
    read_i = 1'b0;
    write_i = 1'b0;
    tick();
    chk("b2b_idle_read_o", read_o, 0);

    // reset mid-read after two beats
    address_i = 32'h0000_0040;
    read_i = 1'b1;
    tick();
    resp_i = 1'b1;
    burst_i = B1;
    tick();
    burst_i = B2;
    tick();
    resp_i = 1'b0;
    read_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_read_o", read_o, 0);
    chk("mid_rst_resp_o", resp_o, 0);
    chk("mid_rst_line_o", line_o, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_resp_o", resp_o, 0);
    address_i = 32'h0000_1234;
    read_i = 1'b1;
    tick();
    rbeats = '{D0, D1, D2, D3};
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = rbeats[i];
      tick();
    end
    resp_i = 1'b0;
    chk("post_rst_done_resp_o", resp_o, 1);
    chk("post_rst_line_o", line_o, {D3, D2, D1, D0});
    tick();
    read_i = 1'b0;
    tick();

    // idle noise
    last_line = {D3, D2, D1, D0};
    for (int i = 0; i < 8; i++) begin
      resp_i = i[0];
      burst_i = {$urandom, $urandom};
      tick();
      chk("idle_resp_o", resp_o, 0);
      chk("idle_read_o", read_o, 0);
      chk("idle_write_o", write_o, 0);
      chk("idle_line_o", line_o, last_line);
    end
    resp_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
